// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin, packet-granular arbiter for the UART TX FIFO write port (UART_TX_ARB_PRIO_EN makes requester 0 strict high priority)
module uart_tx_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arb_en,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        tx_fifo_wfull,
  output logic                        tx_fifo_wr_en,
  output logic [DATA_W-1:0]           tx_data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);
  localparam int GW = $clog2(NUM_REQ);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;
  logic [0:0]    state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] win;
  logic [GW-1:0] idx;
  logic [GW-1:0] nxt_ptr;
  logic [7:0]    burst_cnt;
  logic          xfer;
  logic          fin;
  assign busy          = state == XFER;
  assign xfer          = busy & req_valid[grant_id] & ~tx_fifo_wfull;
  assign tx_fifo_wr_en = xfer;
  assign tx_data       = xfer ? req_data[grant_id*DATA_W +: DATA_W] : '0;
  assign fin           = xfer & (req_last[grant_id] | burst_cnt == 8'(MAX_BURST-1));
  assign nxt_ptr       = grant_id == GW'(NUM_REQ-1) ? '0 : grant_id + 1'b1;
  // only the current grantee sees ready, and only while the FIFO has room
  always_comb begin
    req_ready = '0;
    if (busy) req_ready[grant_id] = ~tx_fifo_wfull;
  end
  // first valid requester at or after rr_ptr, wrapping; scanned downward so the nearest wins
  always_comb begin
    win = rr_ptr;
    idx = rr_ptr;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = GW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[idx]) win = idx;
    end
`ifdef UART_TX_ARB_PRIO_EN
    if (req_valid[0]) win = '0;
`endif
  end
  // grant in IDLE, count bytes in XFER, release on last byte or burst cap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (!busy) begin
      if (arb_en && |req_valid) begin
        state     <= XFER;
        grant_id  <= win;
        burst_cnt <= '0;
      end
    end else if (xfer) begin
      burst_cnt <= burst_cnt + 1'b1;
      if (fin) begin
        state <= IDLE;
`ifdef UART_TX_ARB_PRIO_EN
        if (grant_id != '0) rr_ptr <= nxt_ptr;
`else
        rr_ptr <= nxt_ptr;
`endif
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench for uart_tx_arb with per-scenario tasks
module tb_uart_tx_arb;
  logic        clk = 0;
  logic        rst = 1;
  logic        arb_en = 0;
  logic        tx_fifo_wfull = 0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_fifo_wr_en;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic [8:0]  src[4][$];
  logic [9:0]  exp_q[$];
  logic [3:0]  acc;
  logic [3:0]  rdy_s;
  logic        wr_s;
  logic        busy_s;
  logic [1:0]  gid_s;
  int checks = 0;
  int failures = 0;

  uart_tx_arb dut (
    .clk(clk), .rst(rst), .arb_en(arb_en), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_fifo_wfull(tx_fifo_wfull),
    .tx_fifo_wr_en(tx_fifo_wr_en), .tx_data(tx_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // one clock: present source heads, sample at negedge, score writes, retire accepted bytes
  task automatic tick();
    logic [9:0] e;
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = src[i].size() > 0;
      req_data[i*8 +: 8] = req_valid[i] ? src[i][0][7:0] : 8'h00;
      req_last[i] = req_valid[i] ? src[i][0][8] : 1'b0;
    end
    @(negedge clk);
    acc = req_valid & req_ready;
    wr_s = tx_fifo_wr_en;
    busy_s = busy;
    gid_s = grant_id;
    rdy_s = req_ready;
    if (tx_fifo_wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_write got=%h required=none", {grant_id, tx_data});
      end else begin
        e = exp_q.pop_front();
        if ({grant_id, tx_data} !== e) begin
          failures++;
          $display("FAIL sb_write got=%h required=%h", {grant_id, tx_data}, e);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) void'(src[i].pop_front());
  endtask

  task automatic run_until_empty(input int bound);
    for (int t = 0; t < bound && exp_q.size() > 0; t++) tick();
  endtask

  task automatic do_reset();
    rst = 1;
    for (int i = 0; i < 4; i++) src[i].delete();
    exp_q.delete();
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    arb_en = 1;
    req_valid = '1;
    req_last = '1;
    req_data = 32'h55555555;
    tx_fifo_wfull = 0;
    @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (tx_fifo_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%b required=0", tx_fifo_wr_en); end
    if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data got=%h required=00", tx_data); end
    if (req_ready !== 4'h0) begin failures++; $display("FAIL rst_req_ready got=%b required=0000", req_ready); end
    if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_grant_id got=%0d required=0", grant_id); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b required=0", busy); end
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL post_rst_busy got=%b required=0", busy); end
    if (tx_fifo_wr_en !== 1'b0) begin failures++; $display("FAIL post_rst_wr_en got=%b required=0", tx_fifo_wr_en); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [4:0] wp;
    src[2].push_back({1'b0, 8'hA1});
    src[2].push_back({1'b0, 8'hA2});
    src[2].push_back({1'b1, 8'hA3});
    exp_q.push_back({2'd2, 8'hA1});
    exp_q.push_back({2'd2, 8'hA2});
    exp_q.push_back({2'd2, 8'hA3});
    for (int t = 0; t < 5; t++) begin
      tick();
      wp[t] = wr_s;
      if (t == 1) begin
        checks++;
        if (gid_s !== 2'd2) begin failures++; $display("FAIL single_grant got=%0d required=2", gid_s); end
      end
    end
    checks += 3;
    if (wp !== 5'b01110) begin failures++; $display("FAIL single_wr_timing got=%b required=01110", wp); end
    if (busy_s !== 1'b0) begin failures++; $display("FAIL single_idle_after got=%b required=0", busy_s); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL single_drain left=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_rr_after_single();
    src[0].push_back({1'b1, 8'h10});
    src[3].push_back({1'b1, 8'h30});
`ifdef UART_TX_ARB_PRIO_EN
    exp_q.push_back({2'd0, 8'h10});
    exp_q.push_back({2'd3, 8'h30});
`else
    exp_q.push_back({2'd3, 8'h30});
    exp_q.push_back({2'd0, 8'h10});
`endif
    run_until_empty(20);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rr_ptr_drain left=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_fairness();
    logic [15:0] wp;
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        src[i].push_back({1'b1, 8'(16*i + k)});
        exp_q.push_back({2'(i), 8'(16*i + k)});
      end
    for (int t = 0; t < 16; t++) begin
      tick();
      wp[t] = wr_s;
    end
    checks += 2;
    if (wp !== 16'hAAAA) begin failures++; $display("FAIL fair_wr_spacing got=%h required=aaaa", wp); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL fair_drain left=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [9:0] wp;
    logic [9:0] rp;
    for (int k = 0; k < 4; k++) begin
      src[1].push_back({k == 3, 8'hB1 + 8'(k)});
      exp_q.push_back({2'd1, 8'hB1 + 8'(k)});
    end
    for (int t = 0; t < 10; t++) begin
      tx_fifo_wfull = t >= 3 && t <= 7;
      tick();
      wp[t] = wr_s;
      rp[t] = rdy_s[1];
    end
    tx_fifo_wfull = 0;
    checks += 3;
    if (wp !== 10'h306) begin failures++; $display("FAIL bp_wr_en got=%b required=1100000110", wp); end
    if (rp !== 10'h306) begin failures++; $display("FAIL bp_ready got=%b required=1100000110", rp); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL bp_drain left=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_burst_cap();
    do_reset();
    for (int k = 0; k < 40; k++) src[1].push_back({1'b0, 8'(k)});
    src[3].push_back({1'b0, 8'hC0});
    src[3].push_back({1'b1, 8'hC1});
    for (int k = 0; k < 16; k++) exp_q.push_back({2'd1, 8'(k)});
    exp_q.push_back({2'd3, 8'hC0});
    exp_q.push_back({2'd3, 8'hC1});
    for (int k = 16; k < 40; k++) exp_q.push_back({2'd1, 8'(k)});
    run_until_empty(200);
    for (int t = 0; t < 3; t++) tick();
    checks += 3;
    if (exp_q.size() != 0) begin failures++; $display("FAIL burst_drain left=%0d required=0", exp_q.size()); end
    if (busy_s !== 1'b1) begin failures++; $display("FAIL burst_hold_busy got=%b required=1", busy_s); end
    if (gid_s !== 2'd1) begin failures++; $display("FAIL burst_hold_grant got=%0d required=1", gid_s); end
    req_valid = 4'b0010;
    req_data[15:8] = 8'hEE;
    req_last = '0;
    #1;
    checks++;
    if (tx_fifo_wr_en !== 1'b1) begin failures++; $display("FAIL midpkt_pending got=%b required=1", tx_fifo_wr_en); end
    rst = 1;
    #1;
    checks += 3;
    if (tx_fifo_wr_en !== 1'b0) begin failures++; $display("FAIL midpkt_rst_wr_en got=%b required=0", tx_fifo_wr_en); end
    if (busy !== 1'b0) begin failures++; $display("FAIL midpkt_rst_busy got=%b required=0", busy); end
    if (grant_id !== 2'd0) begin failures++; $display("FAIL midpkt_rst_grant got=%0d required=0", grant_id); end
    @(posedge clk);
    #1;
    rst = 0;
    req_valid = '0;
    req_data = '0;
  endtask

  task automatic test_prio();
    do_reset();
    src[1].push_back({1'b1, 8'h11});
    exp_q.push_back({2'd1, 8'h11});
    run_until_empty(10);
    src[0].push_back({1'b1, 8'h01});
    src[2].push_back({1'b1, 8'h22});
`ifdef UART_TX_ARB_PRIO_EN
    exp_q.push_back({2'd0, 8'h01});
    exp_q.push_back({2'd2, 8'h22});
`else
    exp_q.push_back({2'd2, 8'h22});
    exp_q.push_back({2'd0, 8'h01});
`endif
    tick();
    tick();
    checks++;
`ifdef UART_TX_ARB_PRIO_EN
    if (gid_s !== 2'd0) begin failures++; $display("FAIL prio_grant got=%0d required=0", gid_s); end
`else
    if (gid_s !== 2'd2) begin failures++; $display("FAIL prio_grant got=%0d required=2", gid_s); end
`endif
    run_until_empty(20);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL prio_drain left=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_arb_en();
    logic any_busy;
    arb_en = 0;
    any_busy = 0;
    src[2].push_back({1'b0, 8'h31});
    src[2].push_back({1'b1, 8'h32});
    for (int t = 0; t < 4; t++) begin
      tick();
      any_busy |= busy_s;
    end
    checks++;
    if (any_busy !== 1'b0) begin failures++; $display("FAIL arb_dis_busy got=%b required=0", any_busy); end
    exp_q.push_back({2'd2, 8'h31});
    exp_q.push_back({2'd2, 8'h32});
    arb_en = 1;
    tick();
    tick();
    arb_en = 0;
    tick();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL arb_off_completes left=%0d required=0", exp_q.size()); end
    src[0].push_back({1'b1, 8'h41});
    any_busy = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      any_busy |= busy_s;
    end
    checks++;
    if (any_busy !== 1'b0) begin failures++; $display("FAIL arb_off_holds_idle got=%b required=0", any_busy); end
    exp_q.push_back({2'd0, 8'h41});
    arb_en = 1;
    run_until_empty(10);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL arb_reen_drain left=%0d required=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_after_single();
    test_fairness();
    test_backpressure();
    test_burst_cap();
    test_prio();
    test_arb_en();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
